// File: rtl/ssd1306_pkg.sv
// Shared opcodes, enums and address widths for the SSD1306 command controller.
package ssd1306_pkg;

  localparam int COL_W  = 7;
  localparam int PAGE_W = 3;
  localparam int ADDR_W = PAGE_W + COL_W;

  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
  localparam logic [7:0] CMD_NORM     = 8'hA6;
  localparam logic [7:0] CMD_INV      = 8'hA7;
  localparam logic [7:0] CMD_MODE     = 8'h20;
  localparam logic [7:0] CMD_COLADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGEADDR = 8'h22;
  localparam logic [7:0] CMD_CONTRAST = 8'h81;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'd0,
    MODE_VERT  = 2'd1,
    MODE_PAGE  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG1,
    ST_ARG2,
    ST_WRITE
  } state_e;

  // Panel-hardware commands that take one argument we have no use for.
  function automatic logic is_one_arg_discard(input logic [7:0] op);
    case (op)
      8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_addr_ptr.sv
// Column/page write pointer with addressing window and auto-advance per mode.
module ssd1306_addr_ptr
  import ssd1306_pkg::*;
#(
  parameter int CW = COL_W,
  parameter int PW = PAGE_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] ld_val,
  input  logic          mode_ld,
  input  logic          col_lo_ld,
  input  logic          col_hi_ld,
  input  logic          page_ld,
  input  logic          col_start_ld,
  input  logic          col_end_ld,
  input  logic          page_start_ld,
  input  logic          page_end_ld,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [PW-1:0] page
);

  mode_e         mode_q, mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;

  always_comb begin
    mode_d       = mode_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;

    if (mode_ld) mode_d = (ld_val[1:0] == 2'd3) ? MODE_PAGE : mode_e'(ld_val[1:0]);
    if (col_lo_ld) col_d[3:0] = ld_val[3:0];
    if (col_hi_ld) col_d[CW-1:4] = ld_val[CW-5:0];
    if (page_ld) page_d = ld_val[PW-1:0];
    if (col_start_ld) begin
      col_start_d = ld_val;
      col_d       = ld_val;
    end
    if (col_end_ld) col_end_d = ld_val;
    if (page_start_ld) begin
      page_start_d = ld_val[PW-1:0];
      page_d       = ld_val[PW-1:0];
    end
    if (page_end_ld) page_end_d = ld_val[PW-1:0];

    // Increments wrap at the field width, so start>end windows simply
    // run around until they meet the end bound.
    if (advance) begin
      case (mode_q)
        MODE_HORIZ: begin
          if (col_q == col_end_q) begin
            col_d  = col_start_q;
            page_d = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        MODE_VERT: begin
          if (page_q == page_end_q) begin
            page_d = page_start_q;
            col_d  = (col_q == col_end_q) ? col_start_q : col_q + CW'(1);
          end else begin
            page_d = page_q + PW'(1);
          end
        end
        default: col_d = col_q + CW'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q       <= MODE_PAGE;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= '1;
      page_start_q <= '0;
      page_end_q   <= '1;
    end else begin
      mode_q       <= mode_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
    end
  end

  assign col  = col_q;
  assign page = page_q;

endmodule

// File: rtl/ssd1306_cmd_ctrl.sv
// SSD1306 host byte decoder: display config registers plus addressed
// framebuffer writes over a valid/ack handshake.
module ssd1306_cmd_ctrl
  import ssd1306_pkg::*;
#(
  parameter int         COLS         = 128,
  parameter int         PAGES        = 8,
  parameter logic [7:0] CONTRAST_RST = 8'h7F
) (
  input  logic                                   CLK25MHz,
  input  logic                                   reset_n,
  input  logic                                   byte_valid,
  output logic                                   byte_ready,
  input  logic                                   byte_dc,
  input  logic [7:0]                             byte_data,
  output logic                                   fb_we,
  input  logic                                   fb_ack,
  output logic [$clog2(PAGES)+$clog2(COLS)-1:0]  fb_waddr,
  output logic [7:0]                             fb_wdata,
  output logic                                   disp_on,
  output logic                                   invert,
  output logic [7:0]                             contrast
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic             fb_we_q, fb_we_d;
  logic [PW+CW-1:0] fb_waddr_q, fb_waddr_d;
  logic [7:0]       fb_wdata_q, fb_wdata_d;
  logic             disp_on_q, disp_on_d, invert_q, invert_d;
  logic [7:0]       contrast_q, contrast_d;

  logic          xfer;
  logic          mode_ld, col_lo_ld, col_hi_ld, page_ld;
  logic          col_start_ld, col_end_ld, page_start_ld, page_end_ld, advance;
  logic [CW-1:0] col;
  logic [PW-1:0] page;

  assign byte_ready = reset_n && (state_q != ST_WRITE);
  assign xfer       = byte_valid && byte_ready;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    fb_we_d       = fb_we_q;
    fb_waddr_d    = fb_waddr_q;
    fb_wdata_d    = fb_wdata_q;
    disp_on_d     = disp_on_q;
    invert_d      = invert_q;
    contrast_d    = contrast_q;
    mode_ld       = 1'b0;
    col_lo_ld     = 1'b0;
    col_hi_ld     = 1'b0;
    page_ld       = 1'b0;
    col_start_ld  = 1'b0;
    col_end_ld    = 1'b0;
    page_start_ld = 1'b0;
    page_end_ld   = 1'b0;
    advance       = 1'b0;

    if (state_q == ST_WRITE) begin
      if (fb_ack) begin
        fb_we_d = 1'b0;
        advance = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (xfer) begin
      if (byte_dc) begin
        // Data also aborts any half-received command.
        fb_wdata_d = byte_data;
        fb_waddr_d = {page, col};
        fb_we_d    = 1'b1;
        state_d    = ST_WRITE;
      end else if (state_q == ST_IDLE) begin
        casez (byte_data)
          CMD_DISP_OFF: disp_on_d = 1'b0;
          CMD_DISP_ON:  disp_on_d = 1'b1;
          CMD_NORM:     invert_d  = 1'b0;
          CMD_INV:      invert_d  = 1'b1;
          8'b0000_????: col_lo_ld = 1'b1;
          8'b0001_0???: col_hi_ld = 1'b1;
          8'b1011_0???: page_ld   = 1'b1;
          CMD_MODE, CMD_COLADDR, CMD_PAGEADDR, CMD_CONTRAST: begin
            op_d    = byte_data;
            state_d = ST_ARG1;
          end
          default: begin
            if (is_one_arg_discard(byte_data)) begin
              op_d    = byte_data;
              state_d = ST_ARG1;
            end
          end
        endcase
      end else if (state_q == ST_ARG1) begin
        state_d = ST_IDLE;
        case (op_q)
          CMD_MODE:     mode_ld    = 1'b1;
          CMD_CONTRAST: contrast_d = byte_data;
          CMD_COLADDR: begin
            col_start_ld = 1'b1;
            state_d      = ST_ARG2;
          end
          CMD_PAGEADDR: begin
            page_start_ld = 1'b1;
            state_d       = ST_ARG2;
          end
          default: ;
        endcase
      end else begin
        state_d = ST_IDLE;
        case (op_q)
          CMD_COLADDR:  col_end_ld  = 1'b1;
          CMD_PAGEADDR: page_end_ld = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK25MHz) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      fb_we_q    <= 1'b0;
      fb_waddr_q <= '0;
      fb_wdata_q <= '0;
      disp_on_q  <= 1'b0;
      invert_q   <= 1'b0;
      contrast_q <= CONTRAST_RST;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      fb_we_q    <= fb_we_d;
      fb_waddr_q <= fb_waddr_d;
      fb_wdata_q <= fb_wdata_d;
      disp_on_q  <= disp_on_d;
      invert_q   <= invert_d;
      contrast_q <= contrast_d;
    end
  end

  ssd1306_addr_ptr #(.CW(CW), .PW(PW)) u_ptr (
    .clk          (CLK25MHz),
    .reset_n      (reset_n),
    .ld_val       (byte_data[CW-1:0]),
    .mode_ld      (mode_ld),
    .col_lo_ld    (col_lo_ld),
    .col_hi_ld    (col_hi_ld),
    .page_ld      (page_ld),
    .col_start_ld (col_start_ld),
    .col_end_ld   (col_end_ld),
    .page_start_ld(page_start_ld),
    .page_end_ld  (page_end_ld),
    .advance      (advance),
    .col          (col),
    .page         (page)
  );

  assign fb_we    = fb_we_q;
  assign fb_waddr = fb_waddr_q;
  assign fb_wdata = fb_wdata_q;
  assign disp_on  = disp_on_q;
  assign invert   = invert_q;
  assign contrast = contrast_q;

endmodule

// File: tb/tb_ssd1306_cmd_ctrl.sv
// Directed bench for ssd1306_cmd_ctrl with a behavioural display model.
module tb_ssd1306_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       byte_valid = 1'b0, byte_dc = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready, fb_we, fb_ack, disp_on, invert;
  logic [9:0] fb_waddr;
  logic [7:0] fb_wdata, contrast;
  logic       ack_auto = 1'b1, ack_pulse = 1'b0;

  assign fb_ack = ack_auto | ack_pulse;

  int total = 0, bad = 0;

  always #20 clk = ~clk;

  ssd1306_cmd_ctrl dut (
    .CLK25MHz  (clk),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_dc   (byte_dc),
    .byte_data (byte_data),
    .fb_we     (fb_we),
    .fb_ack    (fb_ack),
    .fb_waddr  (fb_waddr),
    .fb_wdata  (fb_wdata),
    .disp_on   (disp_on),
    .invert    (invert),
    .contrast  (contrast)
  );

  // Display model: plain integers, updated once per accepted host byte.
  int m_disp, m_inv, m_con, m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_op, m_argn;
  logic [17:0] exp_q[$];
  logic [9:0]  obs_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_inv = 0; m_con = 'h7F; m_mode = 2;
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_op = -1; m_argn = 0;
    exp_q.delete();
  endtask

  task automatic model_advance();
    if (m_mode == 0) begin
      if (m_col == m_ce) begin
        m_col  = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else if (m_mode == 1) begin
      if (m_page == m_pe) begin
        m_page = m_ps;
        m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
      end else m_page = (m_page + 1) % 8;
    end else m_col = (m_col + 1) % 128;
  endtask

  task automatic model_byte(input bit dc, input int d);
    if (dc) begin
      exp_q.push_back({10'(m_page * 128 + m_col), 8'(d)});
      m_op = -1;
      model_advance();
    end else if (m_op < 0) begin
      if (d == 'hAE) m_disp = 0;
      else if (d == 'hAF) m_disp = 1;
      else if (d == 'hA6) m_inv = 0;
      else if (d == 'hA7) m_inv = 1;
      else if (d <= 'h0F) m_col = (m_col / 16) * 16 + d;
      else if (d >= 'h10 && d <= 'h17) m_col = (m_col % 16) + (d - 'h10) * 16;
      else if (d >= 'hB0 && d <= 'hB7) m_page = d - 'hB0;
      else if (d inside {'h20, 'h21, 'h22, 'h81, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB, 'h8D}) begin
        m_op = d; m_argn = 1;
      end
    end else if (m_argn == 1) begin
      if (m_op == 'h20) m_mode = (d % 4 == 3) ? 2 : d % 4;
      if (m_op == 'h81) m_con = d;
      if (m_op == 'h21) begin m_cs = d % 128; m_col = m_cs; end
      if (m_op == 'h22) begin m_ps = d % 8; m_page = m_ps; end
      if (m_op == 'h21 || m_op == 'h22) m_argn = 2;
      else m_op = -1;
    end else begin
      if (m_op == 'h21) m_ce = d % 128;
      if (m_op == 'h22) m_pe = d % 8;
      m_op = -1;
    end
  endtask

  // Present one byte, wait (bounded) for the transfer edge, then update the model.
  task automatic send(input bit dc, input logic [7:0] d);
    bit done = 0;
    byte_valid = 1'b1; byte_dc = dc; byte_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    byte_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: byte %0h never accepted, expected acceptance", d);
    end else model_byte(dc, d);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!fb_we && exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: writes outstanding=%0d expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("disp_on", disp_on, m_disp);
      chk("invert", invert, m_inv);
      chk("contrast", contrast, m_con);
      chk("byte_ready", byte_ready, !fb_we);
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL fb_we: unexpected write addr %0h, expected no write", fb_waddr);
        end else begin
          chk("fb_waddr", fb_waddr, exp_q[0][17:8]);
          chk("fb_wdata", fb_wdata, exp_q[0][7:0]);
          if (fb_ack) begin
            obs_q.push_back(fb_waddr);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timeout, expected completion");
    $fatal(1, "timeout");
  end

  int base;
  logic [9:0] saved;
  bit bp_done;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_disp_on", disp_on, 0);
    chk("rst_invert", invert, 0);
    chk("rst_contrast", contrast, 8'h7F);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_byte_ready", byte_ready, 1);
    @(posedge clk); #1;

    send(0, 8'hAF); send(0, 8'hA7);
    chk("disp_on_set", disp_on, 1);
    chk("invert_set", invert, 1);
    send(0, 8'h81); send(0, 8'h40);
    chk("contrast_set", contrast, 8'h40);

    // Page mode with column wrap.
    send(0, 8'hB3); send(0, 8'h0F); send(0, 8'h17);
    base = obs_q.size();
    send(1, 8'h55);
    chk("we_latency", fb_we, 1);
    chk("page_data", fb_wdata, 8'h55);
    send(1, 8'h56);
    drain();
    chk("page_addr0", obs_q[base], 10'h1FF);
    chk("page_addr1", obs_q[base+1], 10'h180);

    // Horizontal window.
    send(0, 8'h20); send(0, 8'h00);
    send(0, 8'h21); send(0, 8'd10); send(0, 8'd11);
    send(0, 8'h22); send(0, 8'd6); send(0, 8'd7);
    base = obs_q.size();
    for (int i = 0; i < 5; i++) send(1, 8'(8'h10 + i));
    drain();
    chk("horiz_a0", obs_q[base],   10'h30A);
    chk("horiz_a1", obs_q[base+1], 10'h30B);
    chk("horiz_a2", obs_q[base+2], 10'h38A);
    chk("horiz_a3", obs_q[base+3], 10'h38B);
    chk("horiz_a4", obs_q[base+4], 10'h30A);

    // Vertical window.
    send(0, 8'h20); send(0, 8'h01);
    send(0, 8'h21); send(0, 8'd0); send(0, 8'd1);
    send(0, 8'h22); send(0, 8'd0); send(0, 8'd1);
    base = obs_q.size();
    for (int i = 0; i < 3; i++) send(1, 8'(8'h20 + i));
    drain();
    chk("vert_a0", obs_q[base],   10'h000);
    chk("vert_a1", obs_q[base+1], 10'h080);
    chk("vert_a2", obs_q[base+2], 10'h001);

    // Backpressure: write held, waiting byte not taken.
    ack_auto = 1'b0;
    base = obs_q.size();
    send(1, 8'h3C);
    chk("bp_latency", fb_we, 1);
    saved = fb_waddr;
    chk("bp_addr0", saved, 10'h081);
    bp_done = 0;
    fork
      begin send(1, 8'h99); bp_done = 1; end
    join_none
    repeat (5) begin
      @(negedge clk);
      chk("bp_we", fb_we, 1);
      chk("bp_ready", byte_ready, 0);
      chk("bp_addr", fb_waddr, saved);
      chk("bp_data", fb_wdata, 8'h3C);
    end
    @(posedge clk); #1 ack_pulse = 1'b1;
    @(posedge clk); #1 ack_pulse = 1'b0;
    @(negedge clk);
    chk("bp_ready_after", byte_ready, 1);
    chk("bp_single_write", obs_q.size(), base + 1);
    for (int i = 0; i < 20 && !bp_done; i++) @(posedge clk);
    #1;
    chk("bp_second_taken", bp_done, 1);
    ack_auto = 1'b1;
    drain();
    chk("bp_second_addr", obs_q[base+1], 10'h000);

    // Abort: data during a pending column-address command.
    base = obs_q.size();
    send(0, 8'h21); send(1, 8'hAA); send(1, 8'hAB);
    drain();
    chk("abort_a0", obs_q[base],   10'h080);
    chk("abort_a1", obs_q[base+1], 10'h001);

    // Reset while a write is pending.
    ack_auto = 1'b0;
    send(1, 8'h77);
    chk("rst_mid_we", fb_we, 1);
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    chk("rst2_fb_we", fb_we, 0);
    chk("rst2_disp_on", disp_on, 0);
    chk("rst2_invert", invert, 0);
    chk("rst2_contrast", contrast, 8'h7F);
    chk("rst2_byte_ready", byte_ready, 0);
    ack_auto = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    base = obs_q.size();
    send(1, 8'h12); send(1, 8'h13);
    drain();
    chk("post_rst_a0", obs_q[base],   10'h000);
    chk("post_rst_a1", obs_q[base+1], 10'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
